// File: rtl/data_memory_pkg.sv
// Shared types and widths for the block-addressed data memory.
package data_memory_pkg;

  localparam int unsigned BLOCK_BYTES    = 16;
  localparam int unsigned BLOCK_WIDTH    = 128;
  localparam int unsigned MEM_ADDR_WIDTH = 28;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory.sv
// Main memory behind the data cache: one 128-bit block per access with a
// fixed multi-cycle latency; busywait stalls the requester meanwhile.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 64,
  parameter int unsigned LATENCY    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      read,
  input  logic                      write,
  input  logic [MEM_ADDR_WIDTH-1:0] address,
  input  logic [BLOCK_WIDTH-1:0]    writedata,
  output logic [BLOCK_WIDTH-1:0]    readdata,
  output logic                      busywait
);

  localparam int unsigned IDX_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned OFF_W     = $clog2(BLOCK_BYTES);
  localparam int unsigned BADDR_W   = IDX_W + OFF_W;
  localparam int unsigned NUM_BYTES = NUM_BLOCKS * BLOCK_BYTES;
  localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   accept, xfer;

  logic                   op_write_q;
  logic [IDX_W-1:0]       idx_q;
  logic [BLOCK_WIDTH-1:0] wdata_q;
  logic [BADDR_W-1:0]     base;

  logic [7:0] mem_array [NUM_BYTES];

  // State and latency counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and transfer strobes
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    xfer       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (read || write) begin
          accept     = 1'b1;
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          xfer       = 1'b1;
          state_next = ST_COMPLETE;
        end
      end
      ST_COMPLETE: state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  assign busywait = ((state == ST_IDLE) && (read || write)) || (state == ST_ACCESS);

  // Request capture; a simultaneous read and write is treated as a write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      op_write_q <= write;
      idx_q      <= IDX_W'(address % MEM_ADDR_WIDTH'(NUM_BLOCKS));
      wdata_q    <= writedata;
    end
  end

  assign base = {idx_q, OFF_W'(0)};

  // Storage and read-data register; both cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_BYTES); i++) begin
        mem_array[i] <= '0;
      end
      readdata <= '0;
    end else if (xfer) begin
      for (int k = 0; k < int'(BLOCK_BYTES); k++) begin
        if (op_write_q) begin
          mem_array[base + BADDR_W'(k)] <= wdata_q[8*k +: 8];
        end else begin
          readdata[8*k +: 8] <= mem_array[base + BADDR_W'(k)];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;

  localparam int unsigned NB  = 64;
  localparam int unsigned LAT = 16;

  logic         clk;
  logic         reset;
  logic         read;
  logic         write;
  logic [27:0]  address;
  logic [127:0] writedata;
  logic [127:0] readdata;
  logic         busywait;

  int checks   = 0;
  int failures = 0;

  data_memory #(.NUM_BLOCKS(NB), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one access from IDLE and hold it until completion; address and
  // writedata are disturbed after acceptance to show they were latched.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [27:0] addr, input logic [27:0] addr_after,
                        input logic [127:0] data);
    read      = rd;
    write     = wr;
    address   = addr;
    writedata = data;
    #1;
    check({tag, "_busy_req"}, 128'(busywait), 128'(1));
    @(posedge clk); #1;
    address   = addr_after;
    writedata = ~data;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check({tag, "_busy_lat"}, 128'(busywait), 128'(1));
    @(posedge clk); #1;
    check({tag, "_busy_done"}, 128'(busywait), 128'(0));
    read  = 1'b0;
    write = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] mem_block(input int idx);
    logic [127:0] b;
    for (int k = 0; k < 16; k++) b[8*k +: 8] = dut.mem_array[idx*16 + k];
    return b;
  endfunction

  localparam logic [127:0] PAT_A = 128'hABCD1234_ABCD1234_ABCD1234_ABCD1234;
  localparam logic [127:0] PAT_5 = {16{8'h55}};

  initial begin
    logic [7:0] acc;
    int errs;
    int lows;
    logic exp_busy;

    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    #1;
    check("rst_readdata", readdata, 128'h0);
    check("rst_busy", 128'(busywait), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mem0", 128'(dut.mem_array[0]), 128'h0);

    // Write then read back block 0
    access("wr0", 1'b0, 1'b1, 28'd0, 28'd0, PAT_A);
    check("wr0_byte0", 128'(dut.mem_array[0]), 128'h34);
    check("wr0_byte15", 128'(dut.mem_array[15]), 128'hAB);
    access("rd0", 1'b1, 1'b0, 28'd0, 28'd0, 128'h0);
    check("rd0_data", readdata, PAT_A);

    // Address wrap and block isolation
    access("wrap", 1'b0, 1'b1, 28'(NB + 3), 28'(NB + 3), 128'h1);
    access("rd3", 1'b1, 1'b0, 28'd3, 28'd3, 128'h0);
    check("rd3_data", readdata, 128'h1);
    access("rd2", 1'b1, 1'b0, 28'd2, 28'd2, 128'h0);
    check("rd2_data", readdata, 128'h0);

    // Read+write acts as a write; address changes during ACCESS are ignored
    access("rd0b", 1'b1, 1'b0, 28'd0, 28'd0, 128'h0);
    check("rd0b_data", readdata, PAT_A);
    access("both", 1'b1, 1'b1, 28'd5, 28'd6, PAT_5);
    check("both_readdata", readdata, PAT_A);
    check("both_blk5", mem_block(5), PAT_5);
    check("both_blk6", mem_block(6), 128'h0);
    access("rd5", 1'b1, 1'b0, 28'd5, 28'd5, 128'h0);
    check("rd5_data", readdata, PAT_5);

    // Back-to-back: a held request sees exactly one idle COMPLETE cycle per access
    errs = 0;
    lows = 0;
    read = 1'b1;
    address = 28'd0;
    for (int i = 0; i < int'(3 * (LAT + 2)); i++) begin
      #1;
      exp_busy = ((i % int'(LAT + 2)) != int'(LAT + 1));
      if (busywait !== exp_busy) errs++;
      if (busywait === 1'b0) lows++;
      @(posedge clk);
    end
    #1;
    read = 1'b0;
    check("b2b_pattern_errs", 128'(errs), 128'(0));
    check("b2b_low_cycles", 128'(lows), 128'(3));
    check("b2b_readdata", readdata, PAT_A);

    // Reset pulse mid-access abandons the write and clears everything
    write     = 1'b1;
    address   = 28'd3;
    writedata = '1;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", 128'(busywait), 128'(1));
    write = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 128'(busywait), 128'(0));
    check("mid_rst_readdata", readdata, 128'h0);
    check("mid_rst_blk3", mem_block(3), 128'h0);
    acc = '0;
    for (int i = 0; i < int'(NB * 16); i++) acc |= dut.mem_array[i];
    check("mid_rst_all_zero", 128'(acc), 128'h0);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    access("post_rst", 1'b1, 1'b0, 28'd0, 28'd0, 128'h0);
    check("post_rst_data", readdata, 128'h0);
    check("post_rst_blk3", mem_block(3), 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
